// File: rtl/prog_memory.sv
// Instruction store with 1-cycle registered fetch, direct word write and a streaming burst loader.
// Fetch latency 1 cycle; the loader holds ld_ready high only while bursting, and ld_valid low stalls it indefinitely.
module prog_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              zero_len_done;

    // Contents start at zero and survive rst; only writes change them.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic is_idle;
    logic start_ok;
    logic start_burst;
    logic start_empty;
    logic beat;
    logic last_beat;

    assign is_idle     = (state == IDLE);
    assign start_ok    = is_idle && load_start;
    assign start_burst = start_ok && (load_len != '0);
    assign start_empty = start_ok && (load_len == '0);
    assign beat        = ld_valid && ld_ready;
    assign last_beat   = beat && (cnt == (ADDR_W + 1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_burst) state_nxt = LOAD;
            LOAD:    if (last_beat)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length start never leaves IDLE, so its done pulse comes from a side flop.
    always_comb begin
        ld_ready  = 1'b0;
        load_busy = 1'b0;
        load_done = zero_len_done;
        case (state)
            LOAD: begin
                ld_ready  = 1'b1;
                load_busy = 1'b1;
            end
            DONE:    load_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            cnt           <= '0;
            zero_len_done <= 1'b0;
        end else begin
            zero_len_done <= start_empty;
            if (start_burst) begin
                ptr <= load_base;
                cnt <= load_len;
            end else if (beat) begin
                ptr <= ptr + ADDR_W'(1);
                cnt <= cnt - (ADDR_W + 1)'(1);
            end
        end
    end

    // Loader beats and direct writes are exclusive: direct writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (beat) begin
                mem[ptr] <= ld_data;
            end else if (wr_en && is_idle) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            fetch_valid <= fetch_en && is_idle;
            if (fetch_en && is_idle) begin
                fetch_data <= mem[fetch_addr];
            end
        end
    end

endmodule

// File: tb/tb_prog_memory.sv
// Randomised self-checking bench for prog_memory against an array-based memory model.
module tb_prog_memory;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_len;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        load_busy;
    logic        load_done;
    logic        fetch_en;
    logic [5:0]  fetch_addr;
    logic [15:0] fetch_data;
    logic        fetch_valid;

    logic [15:0] model_mem [64];
    logic [15:0] burst_dat [64];
    int checks;
    int errors;

    prog_memory #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .load_busy(load_busy), .load_done(load_done),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] a, output logic [15:0] d, output logic v);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        d = fetch_data;
        v = fetch_valid;
        fetch_en = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Drives one burst: start, beats with the chosen valid pattern, then two trailing cycles.
    task automatic drive_burst(input int base, input int len, input int mode,
                               output int pulses, output bit on_time, output bit timed_out);
        int  b;
        bit  v;
        bit  rdy;
        b = 0; pulses = 0; on_time = 1'b0; timed_out = 1'b0;
        load_start = 1'b1;
        load_base  = 6'(base);
        load_len   = 7'(len);
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 2000 && b < len; c++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_data  = burst_dat[b];
            rdy      = ld_ready;
            tick();
            ld_valid = 1'b0;
            if (v && rdy) b++;
            if (load_done) pulses++;
            if (b == len) on_time = load_done && !ld_ready && !load_busy;
        end
        if (b < len) timed_out = 1'b1;
        tick();
        if (load_done) pulses++;
        tick();
        if (load_done) pulses++;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ld_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl: got %b expected 0000", {ld_ready, load_busy, load_done, fetch_valid});
            end
            checks++;
            if (fetch_data !== 16'h0000) begin
                errors++;
                $display("FAIL reset_fetch_data: got %h expected 0000", fetch_data);
            end
            tick();
        end
        rst = 1'b0;
        tick();
        for (int a = 0; a < 64; a++) begin
            do_fetch(6'(a), d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[a]) begin
                errors++;
                $display("FAIL powerup_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", a, v, d, model_mem[a]);
            end
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_valid: got %b expected 0", fetch_valid);
        end
    endtask

    task automatic test_direct_write();
        logic [5:0]  addrs [3];
        logic [15:0] vals  [3];
        logic [5:0]  a;
        logic [15:0] d;
        logic        v;
        addrs[0] = 6'd0;  vals[0] = 16'hAAAA;
        addrs[1] = 6'd31; vals[1] = 16'h5555;
        addrs[2] = 6'd63; vals[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            do_write(addrs[i], vals[i]);
            model_mem[addrs[i]] = vals[i];
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(addrs[i], d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[addrs[i]]) begin
                errors++;
                $display("FAIL direct_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", addrs[i], v, d, model_mem[addrs[i]]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            a = 6'($urandom_range(0, 63));
            d = 16'($urandom);
            do_write(a, d);
            model_mem[a] = d;
            a = 6'($urandom_range(0, 63));
            do_fetch(a, d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[a]) begin
                errors++;
                $display("FAIL rand_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", a, v, d, model_mem[a]);
            end
        end
        // Same-cycle write and fetch of address 10.
        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 16'hBEEF;
        fetch_en = 1'b1; fetch_addr = 6'd10;
        tick();
        wr_en = 1'b0; fetch_en = 1'b0;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== model_mem[10]) begin
            errors++;
            $display("FAIL rdw_old: got v=%b d=%h expected v=1 d=%h", fetch_valid, fetch_data, model_mem[10]);
        end
        model_mem[10] = 16'hBEEF;
        do_fetch(6'd10, d, v);
        checks++;
        if (v !== 1'b1 || d !== model_mem[10]) begin
            errors++;
            $display("FAIL rdw_new: got v=%b d=%h expected v=1 d=%h", v, d, model_mem[10]);
        end
    endtask

    task automatic test_load_wrap();
        int          pulses;
        bit          on_time;
        bit          to;
        logic [15:0] d;
        logic        v;
        logic [5:0]  a;
        for (int i = 0; i < 4; i++) burst_dat[i] = 16'(16'h1111 * (i + 1));
        drive_burst(62, 4, 1, pulses, on_time, to);
        checks++;
        if (to || pulses != 1 || !on_time) begin
            errors++;
            $display("FAIL wrap_handshake: got timeout=%0d pulses=%0d on_time=%0d expected 0 1 1", to, pulses, on_time);
        end
        for (int i = 0; i < 4; i++) model_mem[(62 + i) % 64] = burst_dat[i];
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ready_after: got %b expected 0", ld_ready);
        end
        for (int i = 0; i < 4; i++) begin
            a = 6'((62 + i) % 64);
            do_fetch(a, d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[a]) begin
                errors++;
                $display("FAIL wrap_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", a, v, d, model_mem[a]);
            end
        end
    endtask

    task automatic test_load_blocked();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 3; i++) burst_dat[i] = 16'($urandom);
        load_start = 1'b1; load_base = 6'd40; load_len = 7'd3;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_busy !== 1'b1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL blk_enter_load: got busy=%b rdy=%b expected 1 1", load_busy, ld_ready);
        end
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hDEAD;
        fetch_en = 1'b1; fetch_addr = 6'd5;
        load_start = 1'b1; load_base = 6'd0; load_len = 7'd10;
        tick();
        wr_en = 1'b0; fetch_en = 1'b0; load_start = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL blk_fetch_valid: got %b expected 0", fetch_valid);
        end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = burst_dat[i];
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL blk_done: got %b expected 1", load_done);
        end
        // A start presented during DONE must also be dropped.
        load_start = 1'b1; load_base = 6'd0; load_len = 7'd10;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL blk_second_start: got done=%b busy=%b expected 0 0", load_done, load_busy);
        end
        tick();
        checks++;
        if (load_busy !== 1'b0) begin
            errors++;
            $display("FAIL blk_stays_idle: got busy=%b expected 0", load_busy);
        end
        for (int i = 0; i < 3; i++) model_mem[40 + i] = burst_dat[i];
        do_fetch(6'd5, d, v);
        checks++;
        if (v !== 1'b1 || d !== model_mem[5]) begin
            errors++;
            $display("FAIL blk_mem5: got v=%b d=%h expected v=1 d=%h", v, d, model_mem[5]);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(6'(40 + i), d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[40 + i]) begin
                errors++;
                $display("FAIL blk_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", 40 + i, v, d, model_mem[40 + i]);
            end
        end
    endtask

    task automatic test_zero_and_full();
        int          pulses;
        bit          on_time;
        bit          to;
        logic [5:0]  zb;
        logic [15:0] d;
        logic        v;
        zb = 6'($urandom_range(0, 63));
        // Zero-length start together with a direct write: write lands, no burst happens.
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'h7777;
        load_start = 1'b1; load_base = zb; load_len = 7'd0;
        tick();
        wr_en = 1'b0; load_start = 1'b0;
        model_mem[7] = 16'h7777;
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b rdy=%b expected 1 0 0", load_done, load_busy, ld_ready);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got done=%b busy=%b expected 0 0", load_done, load_busy);
        end
        do_fetch(zb, d, v);
        checks++;
        if (v !== 1'b1 || d !== model_mem[zb]) begin
            errors++;
            $display("FAIL zero_mem[%0d]: got v=%b d=%h expected v=1 d=%h", zb, v, d, model_mem[zb]);
        end
        do_fetch(6'd7, d, v);
        checks++;
        if (v !== 1'b1 || d !== model_mem[7]) begin
            errors++;
            $display("FAIL zero_wr7: got v=%b d=%h expected v=1 d=%h", v, d, model_mem[7]);
        end
        for (int i = 0; i < 64; i++) burst_dat[i] = 16'(16'h1000 + i);
        drive_burst(0, 64, 0, pulses, on_time, to);
        checks++;
        if (to || pulses != 1 || !on_time) begin
            errors++;
            $display("FAIL full_handshake: got timeout=%0d pulses=%0d on_time=%0d expected 0 1 1", to, pulses, on_time);
        end
        for (int i = 0; i < 64; i++) model_mem[i] = burst_dat[i];
        for (int a = 0; a < 64; a++) begin
            do_fetch(6'(a), d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[a]) begin
                errors++;
                $display("FAIL full_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", a, v, d, model_mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] d;
        logic        v;
        for (int i = 0; i < 5; i++) burst_dat[i] = 16'($urandom);
        load_start = 1'b1; load_base = 6'd20; load_len = 7'd5;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = burst_dat[i];
            tick();
        end
        ld_valid = 1'b0;
        model_mem[20] = burst_dat[0];
        model_mem[21] = burst_dat[1];
        rst = 1'b1;
        #2;
        checks++;
        if ({ld_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 0000", {ld_ready, load_busy, load_done, fetch_valid});
        end
        #1;
        rst = 1'b0;
        ld_valid = 1'b1; ld_data = 16'hC0DE;
        tick();
        ld_valid = 1'b0;
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got done=%b busy=%b rdy=%b expected 0 0 0", load_done, load_busy, ld_ready);
        end
        for (int i = 0; i < 5; i++) begin
            do_fetch(6'(20 + i), d, v);
            checks++;
            if (v !== 1'b1 || d !== model_mem[20 + i] || load_done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_fetch[%0d]: got v=%b d=%h done=%b expected v=1 d=%h done=0", 20 + i, v, d, load_done, model_mem[20 + i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          pulses;
        bit          on_time;
        bit          to;
        int          base;
        int          len;
        logic [5:0]  a;
        logic [5:0]  prev_a;
        for (int n = 0; n < 6; n++) begin
            base = $urandom_range(0, 63);
            len  = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) burst_dat[i] = 16'($urandom);
            drive_burst(base, len, $urandom_range(0, 2), pulses, on_time, to);
            checks++;
            if (to || pulses != 1 || !on_time) begin
                errors++;
                $display("FAIL b2b_handshake[%0d]: got timeout=%0d pulses=%0d on_time=%0d expected 0 1 1", n, to, pulses, on_time);
            end
            for (int i = 0; i < len; i++) model_mem[(base + i) % 64] = burst_dat[i];
            // Pipelined fetches: a new address every cycle.
            prev_a = 6'($urandom_range(0, 63));
            fetch_en = 1'b1; fetch_addr = prev_a;
            tick();
            for (int k = 0; k < 12; k++) begin
                a = 6'($urandom_range(0, 63));
                checks++;
                if (fetch_valid !== 1'b1 || fetch_data !== model_mem[prev_a]) begin
                    errors++;
                    $display("FAIL b2b_fetch[%0d]: got v=%b d=%h expected v=1 d=%h", prev_a, fetch_valid, fetch_data, model_mem[prev_a]);
                end
                fetch_addr = a;
                prev_a = a;
                tick();
            end
            fetch_en = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        load_start = 1'b0; load_base = '0; load_len = '0;
        ld_valid = 1'b0; ld_data = '0; fetch_en = 1'b0; fetch_addr = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;
        test_reset();
        test_direct_write();
        test_load_wrap();
        test_load_blocked();
        test_zero_and_full();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
